// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store unit bus master.
//   mem_size_t   - access size encoding as it appears on req_size
//   lsu_state_t  - bus master FSM states
//   size_mask()  - right-justified byte mask for an access size
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10
  } mem_size_t;

  // Encoding 2'b11 on req_size has no enum member; it is reported as an error.
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } lsu_state_t;

  function automatic logic [3:0] size_mask(input mem_size_t size);
    case (size)
      SIZE_B:  return 4'b0001;
      SIZE_H:  return 4'b0011;
      SIZE_W:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane alignment for the load/store unit.
//   wdata    in  : right-justified store data
//   off      in  : byte offset of the access inside its first word
//   size     in  : access size
//   isSigned in  : sign-extend sub-word loads
//   loBuf    in  : read data of the first beat
//   hiBuf    in  : low 24 bits of the second beat's read data (0 for single beat)
//   wdataRot out : store data rotated onto its byte lanes
//   beMask   out : byte mask shifted by off; [3:0] first beat, [7:4] second beat
//   rdataExt out : merged, right-justified and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  mem_size_t   size,
  input  logic        isSigned,
  input  logic [31:0] loBuf,
  input  logic [23:0] hiBuf,
  output logic [31:0] wdataRot,
  output logic [7:0]  beMask,
  output logic [31:0] rdataExt
);

  logic [31:0] merged;

  always_comb begin
    // Rotate left by 8*off so each store byte lands on its lane; bytes that
    // wrap into low lanes are the ones written by the second beat.
    case (off)
      2'd0:    wdataRot = wdata;
      2'd1:    wdataRot = {wdata[23:0], wdata[31:24]};
      2'd2:    wdataRot = {wdata[15:0], wdata[31:16]};
      default: wdataRot = {wdata[7:0],  wdata[31:8]};
    endcase

    beMask = {4'b0000, size_mask(size)} << off;

    // ({hi, lo} >> 8*off)[31:0]; the top byte of hi can never reach the result.
    case (off)
      2'd0:    merged = loBuf;
      2'd1:    merged = {hiBuf[7:0],  loBuf[31:8]};
      2'd2:    merged = {hiBuf[15:0], loBuf[31:16]};
      default: merged = {hiBuf[23:0], loBuf[31:24]};
    endcase

    case (size)
      SIZE_B:  rdataExt = {{24{isSigned & merged[7]}},  merged[7:0]};
      SIZE_H:  rdataExt = {{16{isSigned & merged[15]}}, merged[15:0]};
      default: rdataExt = merged;
    endcase
  end

endmodule

// File: rtl/lsu_master.sv
// lsu_master: initiator side of the byte-enabled data-memory bus. Accepts one
// load/store at a time, splits word-crossing accesses into two beats, merges
// read beats and returns extended load data.
//   clk, rst                  : clock, asynchronous active-high reset
//   req_valid/req_ready       : core request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata : request fields
//   rsp_valid/rsp_rdata/rsp_err   : one-cycle response; rdata held afterwards
//   bus_req/bus_gnt           : beat request, held until granted
//   bus_we/addr/be/wdata      : beat fields, stable while waiting for grant
//   bus_rvalid/bus_rdata      : beat response
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata
);

  lsu_state_t        state;
  logic              weReg;
  mem_size_t         sizeReg;
  logic              signedReg;
  logic              errReg;
  logic [ADDR_W-3:0] wordAddr;
  logic [1:0]        offReg;
  logic [31:0]       wdataReg;
  logic [31:0]       loBuf;
  logic [23:0]       hiBuf;     // only bytes 0..2 of the second beat are ever used
  logic [31:0]       rdataHold;

  logic [31:0] wdataRot;
  logic [7:0]  beMask;
  logic [31:0] rdataExt;
  logic [31:0] rdataNow;
  logic        twoBeat;
  logic        issuing;

  lsu_align uAlign (
    .wdata    (wdataReg),
    .off      (offReg),
    .size     (sizeReg),
    .isSigned (signedReg),
    .loBuf    (loBuf),
    .hiBuf    (hiBuf),
    .wdataRot (wdataRot),
    .beMask   (beMask),
    .rdataExt (rdataExt)
  );

  // Any enabled lane in the upper half of the shifted mask means the access
  // spills into the next word, i.e. off + bytes > 4.
  assign twoBeat  = |beMask[7:4];
  assign rdataNow = (weReg || errReg) ? 32'd0 : rdataExt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      weReg     <= 1'b0;
      sizeReg   <= SIZE_B;
      signedReg <= 1'b0;
      errReg    <= 1'b0;
      wordAddr  <= '0;
      offReg    <= 2'd0;
      wdataReg  <= 32'd0;
      loBuf     <= 32'd0;
      hiBuf     <= 24'd0;
      rdataHold <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            weReg     <= req_we;
            sizeReg   <= mem_size_t'(req_size);
            signedReg <= req_signed;
            wordAddr  <= req_addr[ADDR_W-1:2];
            offReg    <= req_addr[1:0];
            wdataReg  <= req_wdata;
            loBuf     <= 32'd0;
            hiBuf     <= 24'd0;   // single-beat merges see an all-zero high word
            errReg    <= (req_size == SIZE_ILLEGAL);
            state     <= (req_size == SIZE_ILLEGAL) ? RESP : ISSUE0;
          end
        end
        ISSUE0: if (bus_gnt) state <= WAIT0;
        WAIT0: begin
          if (bus_rvalid) begin
            loBuf <= bus_rdata;
            state <= twoBeat ? ISSUE1 : RESP;
          end
        end
        ISSUE1: if (bus_gnt) state <= WAIT1;
        WAIT1: begin
          if (bus_rvalid) begin
            hiBuf <= bus_rdata[23:0];
            state <= RESP;
          end
        end
        RESP: begin
          rdataHold <= rdataNow;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode the registered state and latched request, so they are
  // stable for as long as a beat waits for grant.
  assign issuing   = (state == ISSUE0) || (state == ISSUE1);
  assign req_ready = (state == IDLE) && !rst;
  assign bus_req   = issuing;
  assign bus_we    = issuing && weReg;
  assign bus_addr  = (state == ISSUE0) ? {wordAddr, 2'b00} :
                     (state == ISSUE1) ? {wordAddr + {{(ADDR_W-3){1'b0}}, 1'b1}, 2'b00} :
                     '0;
  assign bus_be    = (state == ISSUE0) ? beMask[3:0] :
                     (state == ISSUE1) ? beMask[7:4] : 4'b0000;
  assign bus_wdata = issuing ? wdataRot : 32'd0;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = (state == RESP) && errReg;
  assign rsp_rdata = (state == RESP) ? rdataNow : rdataHold;

endmodule

// File: tb/tb_lsu_master.sv
// tb_lsu_master: directed bench for lsu_master. The bus is driven by hand
// inside the sequence; every expected value is a hand-computed constant.
module tb_lsu_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        bus_req;
  logic        bus_gnt;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int errors = 0;
  int checks = 0;

  lsu_master #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample and drive 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input string tag, input logic we, input logic [1:0] size,
                        input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    step();
    req_valid  = 1'b0;
    req_wdata  = 32'd0;
  endtask

  // One zero-wait beat: grant in the issue cycle, rvalid the cycle after.
  task automatic beat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic we, input logic chkW, input logic [31:0] wdata,
                      input logic [31:0] rdata);
    chk({tag, ".bus_req"},  32'(bus_req), 32'd1);
    chk({tag, ".bus_addr"}, bus_addr, addr);
    chk({tag, ".bus_be"},   32'(bus_be), 32'(be));
    chk({tag, ".bus_we"},   32'(bus_we), 32'(we));
    if (chkW) chk({tag, ".bus_wdata"}, bus_wdata, wdata);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    chk({tag, ".bus_req_drop"}, 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = rdata;
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
  endtask

  task automatic resp(input string tag, input logic [31:0] data, input logic err);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, data);
    chk({tag, ".rsp_err"},   32'(rsp_err), 32'(err));
    step();
    chk({tag, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".rdata_hold"}, rsp_rdata, data);
    chk({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    step();
    step();

    // Reset state: every output low.
    chk("rst.bus_req",   32'(bus_req), 32'd0);
    chk("rst.bus_addr",  bus_addr, 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    step();

    // Aligned word store: one beat, response at t+3.
    accept("st_w", 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    beat("st_w", 32'h0000_0100, 4'b1111, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0);
    resp("st_w", 32'h0, 1'b0);

    // Byte loads from the top lane, signed then unsigned.
    accept("ldb_s", 1'b0, 2'b00, 1'b1, 32'h0000_0203, 32'h0);
    beat("ldb_s", 32'h0000_0200, 4'b1000, 1'b0, 1'b0, 32'h0, 32'h80FF_FFFF);
    resp("ldb_s", 32'hFFFF_FF80, 1'b0);
    accept("ldb_u", 1'b0, 2'b00, 1'b0, 32'h0000_0203, 32'h0);
    beat("ldb_u", 32'h0000_0200, 4'b1000, 1'b0, 1'b0, 32'h0, 32'h80FF_FFFF);
    resp("ldb_u", 32'h0000_0080, 1'b0);

    // Misaligned word load crossing a word boundary: response at t+5.
    accept("ldw_mis", 1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0);
    beat("ldw_mis.b0", 32'h0000_00FC, 4'b1100, 1'b0, 1'b0, 32'h0, 32'h3344_AAAA);
    beat("ldw_mis.b1", 32'h0000_0100, 4'b0011, 1'b0, 1'b0, 32'h0, 32'hBBBB_1122);
    resp("ldw_mis", 32'h1122_3344, 1'b0);

    // Misaligned halfword store: same rotated data in both beats.
    accept("sth_mis", 1'b1, 2'b01, 1'b0, 32'h0000_0007, 32'h0000_A55A);
    beat("sth_mis.b0", 32'h0000_0004, 4'b1000, 1'b1, 1'b1, 32'h5A00_00A5, 32'h0);
    beat("sth_mis.b1", 32'h0000_0008, 4'b0001, 1'b1, 1'b1, 32'h5A00_00A5, 32'h0);
    resp("sth_mis", 32'h0, 1'b0);

    // Illegal size: error response at t+1, no bus traffic.
    accept("illegal", 1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0);
    chk("illegal.bus_req", 32'(bus_req), 32'd0);
    resp("illegal", 32'h0, 1'b1);
    chk("illegal.bus_req_after", 32'(bus_req), 32'd0);

    // Grant withheld for 5 cycles; a stray rvalid in ISSUE0 must be ignored.
    accept("stall", 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_0000;
    for (int i = 0; i < 5; i++) begin
      chk("stall.bus_req",  32'(bus_req), 32'd1);
      chk("stall.bus_addr", bus_addr, 32'h0000_0100);
      chk("stall.bus_be",   32'(bus_be), 32'h0000_000C);
      chk("stall.bus_we",   32'(bus_we), 32'd0);
      step();
      bus_rvalid = 1'b0;
      bus_rdata  = 32'd0;
    end
    beat("stall", 32'h0000_0100, 4'b1100, 1'b0, 1'b0, 32'h0, 32'hABCD_0000);
    resp("stall", 32'hFFFF_ABCD, 1'b0);

    // Second beat wraps from the top word to word 0.
    accept("wrap", 1'b0, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0);
    beat("wrap.b0", 32'hFFFF_FFFC, 4'b1000, 1'b0, 1'b0, 32'h0, 32'h7700_0000);
    beat("wrap.b1", 32'h0000_0000, 4'b0001, 1'b0, 1'b0, 32'h0, 32'h0000_0066);
    resp("wrap", 32'h0000_6677, 1'b0);

    // Reset in WAIT1 of a two-beat load abandons it without a response.
    accept("abort", 1'b0, 2'b10, 1'b0, 32'h0000_00FE, 32'h0);
    beat("abort.b0", 32'h0000_00FC, 4'b1100, 1'b0, 1'b0, 32'h0, 32'h3344_AAAA);
    chk("abort.b1_addr", bus_addr, 32'h0000_0100);
    bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort.bus_req",   32'(bus_req), 32'd0);
    chk("abort.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort.rsp_rdata", rsp_rdata, 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hBBBB_1122;
    step();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;
    rst = 1'b0;
    step();
    chk("abort.req_ready", 32'(req_ready), 32'd1);
    chk("abort.no_rsp",    32'(rsp_valid), 32'd0);

    accept("post_rst", 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
    beat("post_rst", 32'h0000_0300, 4'b1111, 1'b0, 1'b0, 32'h0, 32'h1234_5678);
    resp("post_rst", 32'h1234_5678, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_master.md
Name: lsu_master

Overview:
- Initiator side of the byte/halfword/word data-memory interface, sitting in stage M between the core's memory-access request and a word-addressed, byte-enabled memory bus.
- Takes one load/store request at a time and handles misaligned accesses. If the access stays inside one word, it issues one bus beat; if it crosses a word boundary, it issues two.
- Merges read beats, then zero- or sign-extends the result and returns it to the core.

Parameters:
- ADDR_W, 32, width of the byte address on both the request and bus sides.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal
- req_signed  in  1  sign-extend loads (ignored for word accesses)
- req_addr  in  ADDR_W  byte address; any alignment allowed
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse; load data or store completion
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; 1 = illegal size
- bus_req  out  1  bus request; held until granted
- bus_gnt  in  1  beat accepted when bus_req && bus_gnt
- bus_we  out  1  beat is a write
- bus_addr  out  ADDR_W  word-aligned address; bits [1:0] are always 0
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-aligned write data
- bus_rvalid  in  1  beat response; bus_rdata valid for reads
- bus_rdata  in  32  read data

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE; all outputs are 0. A reset in the middle of an operation abandons it and drops bus_req immediately; no rsp_valid is issued.
- One request is outstanding at a time. req_ready = 1 only in IDLE.
- On accept, latch we, size, signed, word address WA = addr[ADDR_W-1:2], off = addr[1:0], and wdata.
- Byte mask m = 0001 / 0011 / 1111 for B / H / W. two_beat = (off + bytes) > 4.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
  - IDLE -> ISSUE0 on accept. If size is 11, go IDLE -> RESP with rsp_err = 1 and make no bus access.
  - ISSUE0: bus_req = 1, bus_addr = {WA, 00}, bus_be = (m << off)[3:0]. On gnt -> WAIT0.
  - WAIT0: on bus_rvalid, store bus_rdata in lo_buf; go to ISSUE1 if two_beat, else RESP.
  - ISSUE1: bus_addr = {WA + 1, 00}, with wrap-around (word 0x3FFFFFFF wraps to 0). bus_be = (m << off)[7:4]. On gnt -> WAIT1.
  - WAIT1: on bus_rvalid, store bus_rdata in hi_buf -> RESP.
  - RESP: rsp_valid = 1 for exactly one cycle -> IDLE.
- Write data: bus_wdata = wdata rotated left by 8*off bits. The same value is driven in both beats; byte enables select the lanes.
- Read merge: r = ({hi_buf, lo_buf} >> 8*off)[31:0]; hi_buf is treated as 0 for single-beat accesses.
- Read extension:
  - byte: r[7:0], extended from bit 7 when signed.
  - halfword: r[15:0], extended from bit 15 when signed.
  - word: r as is.
- All bus outputs stay stable while bus_req = 1 and gnt = 0.
- bus_rvalid is sampled only in WAIT0/WAIT1. The bus never returns rvalid in the grant cycle; rvalid in any other state is ignored.
- Latency with zero-wait bus (gnt in the issue cycle, rvalid the cycle after):
  - aligned access: accept at cycle t, rsp_valid at t+3.
  - two-beat access: rsp_valid at t+5.
- rsp_rdata holds its value until the next RESP; it is 0 after reset.

Decomposition:
- Package lsu_pkg:
  - mem_size_t enum: SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10.
  - lsu_state_t enum for the six FSM states.
  - Function size_mask(mem_size_t) returning the 4-bit byte mask.
- One sub-module, lsu_align: purely combinational. It takes wdata, off, size, signed, lo_buf and hi_buf, and returns rotated write data, the 8-bit shifted mask, and the extended read result. The FSM and latches stay in lsu_master.

Test Plan:
- Aligned word store, addr 0x100, wdata 0xDEADBEEF, zero-wait bus -> single beat: addr 0x100, be 1111, wdata 0xDEADBEEF; rsp_valid at t+3, rsp_rdata 0.
- Signed byte load, addr 0x203, bus returns 0x80FFFFFF -> be 1000, rsp_rdata 0xFFFFFF80. Repeat unsigned -> 0x00000080.
- Misaligned word load, addr 0x0FE -> beat 0 to 0x0FC with be 1100, returning 0x3344AAAA; beat 1 to 0x100 with be 0011, returning 0xBBBB1122; rsp_rdata 0x11223344 at t+5.
- Misaligned halfword store, addr 0x7, wdata 0x0000A55A -> beat 0 to 0x4, be 1000, wdata 0x5A00_00A5; beat 1 to 0x8, be 0001, same wdata.
- Illegal size 11 -> no bus_req ever asserted; rsp_valid with rsp_err = 1 and rsp_rdata 0 at t+1. Also: grant held low for 5 cycles -> bus outputs stable throughout.
- Reset asserted during WAIT1 of a two-beat load -> bus_req and rsp_valid are 0 immediately; after release, req_ready = 1 and the next aligned load completes normally.
